// File: rtl/flux_onset_detector.sv
// flux_onset_detector: spectral-flux onset flagging for the tempo stage.
// Passes the flux stream through with one cycle of latency and flags onsets
// against an adaptive threshold. The threshold is a scaled mean of the
// previous AVG_LEN frames, with an absolute floor and a refractory hold-off.
// Optional feature: define PEAK_PICK_EN to add a local-maximum test. The
// flag is then emitted one frame late, on the frame that follows the peak.
module flux_onset_detector #(
  parameter int W              = 70,
  parameter int AVG_LEN        = 16,
  parameter int THRESH_NUM     = 3,
  parameter int THRESH_SHIFT   = 1,
  parameter int MIN_FLUX       = 64,
  parameter int REFRACT_FRAMES = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flux_valid,
  input  logic [W-1:0] flux_in,
  output logic         flux_out_valid,
  output logic [W-1:0] flux_out,
  output logic         beat_valid,
  output logic [W-1:0] mean_out,
  output logic [15:0]  onset_count
);

  localparam int LG = (AVG_LEN > 1) ? $clog2(AVG_LEN) : 1;
  localparam int SW = W + LG;
  localparam int DW = W + 8;

  typedef enum logic [1:0] {WARMUP, ARMED, REFRACT} state_t;

  state_t          state_q,       state_d;
  logic [LG-1:0]   wr_ptr_q,      wr_ptr_d;
  logic [LG-1:0]   fill_cnt_q,    fill_cnt_d;
  logic [SW-1:0]   sum_q,         sum_d;
  logic [7:0]      refract_cnt_q, refract_cnt_d;
  logic [15:0]     onset_cnt_q,   onset_cnt_d;
  logic            flux_out_valid_q, flux_out_valid_d;
  logic [W-1:0]    flux_out_q,    flux_out_d;
  logic            beat_q,        beat_d;

  logic [W-1:0]    hist_mem [AVG_LEN];
  logic [W-1:0]    oldest;
  logic [W-1:0]    mean_w;
  logic [DW-1:0]   flux_scaled;
  logic [DW-1:0]   mean_scaled;
  logic            above;
  logic            floor_ok;
  logic            pass;
  logic            beat_now;

  // History buffer write; the read below sees the pre-write entry.
  always_ff @(posedge clk) begin
    if (flux_valid) begin
      hist_mem[wr_ptr_q] <= flux_in;
    end
  end

  // Threshold test against the mean of the previous window (current frame excluded).
  always_comb begin
    oldest      = hist_mem[wr_ptr_q];
    mean_w      = W'(sum_q >> LG);
    flux_scaled = DW'(flux_in) << THRESH_SHIFT;
    mean_scaled = DW'(mean_w) * DW'(THRESH_NUM);
    above       = flux_scaled > mean_scaled;
    floor_ok    = flux_in >= W'(MIN_FLUX);
    pass        = above && floor_ok && (state_q == ARMED);
  end

`ifdef PEAK_PICK_EN
  logic [W-1:0] prev_flux_q, prev_flux_d;
  logic         cand_q,      cand_d;
  logic         emit;

  // Peak pick: a passing frame that rose becomes a candidate; it is emitted
  // on the next frame if that frame does not exceed it.
  always_comb begin
    emit        = cand_q && (state_q == ARMED) && (prev_flux_q >= flux_in);
    beat_now    = emit;
    cand_d      = pass && (flux_in > prev_flux_q) && !emit;
    prev_flux_d = flux_in;
  end
`else
  // Direct decision: the frame itself is flagged.
  always_comb begin
    beat_now = pass;
  end
`endif

  // Frame-driven next state: running sum, pointer, FSM and output staging.
  always_comb begin
    state_d          = state_q;
    wr_ptr_d         = wr_ptr_q;
    fill_cnt_d       = fill_cnt_q;
    sum_d            = sum_q;
    refract_cnt_d    = refract_cnt_q;
    onset_cnt_d      = onset_cnt_q;
    flux_out_valid_d = flux_valid;
    flux_out_d       = flux_out_q;
    beat_d           = 1'b0;

    if (flux_valid) begin
      flux_out_d = flux_in;
      beat_d     = beat_now;
      wr_ptr_d   = wr_ptr_q + LG'(1);

      if (state_q == WARMUP) begin
        sum_d = sum_q + SW'(flux_in);
      end else begin
        sum_d = sum_q - SW'(oldest) + SW'(flux_in);
      end

      case (state_q)
        WARMUP: begin
          fill_cnt_d = fill_cnt_q + LG'(1);
          if (fill_cnt_q == LG'(AVG_LEN - 1)) begin
            state_d = ARMED;
          end
        end
        ARMED: begin
          if (beat_now) begin
            onset_cnt_d = onset_cnt_q + 16'd1;
            if (REFRACT_FRAMES != 0) begin
              refract_cnt_d = 8'(REFRACT_FRAMES);
              state_d       = REFRACT;
            end
          end
        end
        REFRACT: begin
          refract_cnt_d = refract_cnt_q - 8'd1;
          // A zero count cannot normally occur here; treat it like 1 so the FSM never sticks.
          if (refract_cnt_q <= 8'd1) begin
            refract_cnt_d = 8'd0;
            state_d       = ARMED;
          end
        end
        default: begin
          state_d = WARMUP;
        end
      endcase
    end
  end

  // State and output registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= WARMUP;
      wr_ptr_q         <= '0;
      fill_cnt_q       <= '0;
      sum_q            <= '0;
      refract_cnt_q    <= '0;
      onset_cnt_q      <= '0;
      flux_out_valid_q <= 1'b0;
      flux_out_q       <= '0;
      beat_q           <= 1'b0;
`ifdef PEAK_PICK_EN
      prev_flux_q      <= '0;
      cand_q           <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      wr_ptr_q         <= wr_ptr_d;
      fill_cnt_q       <= fill_cnt_d;
      sum_q            <= sum_d;
      refract_cnt_q    <= refract_cnt_d;
      onset_cnt_q      <= onset_cnt_d;
      flux_out_valid_q <= flux_out_valid_d;
      flux_out_q       <= flux_out_d;
      beat_q           <= beat_d;
`ifdef PEAK_PICK_EN
      if (flux_valid) begin
        prev_flux_q <= prev_flux_d;
        cand_q      <= cand_d;
      end
`endif
    end
  end

  assign flux_out_valid = flux_out_valid_q;
  assign flux_out       = flux_out_q;
  assign beat_valid     = beat_q;
  assign mean_out       = mean_w;
  assign onset_count    = onset_cnt_q;

endmodule

// File: tb/tb_flux_onset_detector.sv
// Bench for flux_onset_detector: directed scenarios plus randomized frames,
// checked against a frame-history reference model.
module tb_flux_onset_detector;

  localparam int W        = 70;
  localparam int AVG_LEN  = 16;
  localparam int LG       = 4;
  localparam int REFRACT  = 4;
  localparam int MIN_FLUX = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         flux_valid;
  logic [W-1:0] flux_in;
  logic         flux_out_valid;
  logic [W-1:0] flux_out;
  logic         beat_valid;
  logic [W-1:0] mean_out;
  logic [15:0]  onset_count;

  int tests = 0;
  int fails = 0;

  // Reference model state: every accepted frame since reset, in order.
  logic [W-1:0] hist [$];
  int           last_ev;
  logic [15:0]  m_cnt;
  bit           pend;

  flux_onset_detector #(
    .W(W), .AVG_LEN(AVG_LEN), .THRESH_NUM(3), .THRESH_SHIFT(1),
    .MIN_FLUX(MIN_FLUX), .REFRACT_FRAMES(REFRACT)
  ) dut (
    .clk(clk), .reset(reset), .flux_valid(flux_valid), .flux_in(flux_in),
    .flux_out_valid(flux_out_valid), .flux_out(flux_out),
    .beat_valid(beat_valid), .mean_out(mean_out), .onset_count(onset_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Mean of the up-to-AVG_LEN frames preceding index upto.
  function automatic logic [W-1:0] window_mean(input int upto);
    logic [W+7:0] s;
    int lo;
    s  = '0;
    lo = (upto > AVG_LEN) ? upto - AVG_LEN : 0;
    for (int i = lo; i < upto; i++) s += (W+8)'(hist[i]);
    return W'(s >> LG);
  endfunction

  task automatic model_clear();
    hist.delete();
    last_ev = -1000;
    m_cnt   = '0;
    pend    = 1'b0;
  endtask

  // Called at a negedge: drive one cycle, then check outputs at the next negedge.
  task automatic frame(input bit v, input logic [W-1:0] val);
    logic         exp_beat;
    logic         pass;
    logic [W+7:0] mn;
    int           k;
    flux_valid = v;
    flux_in    = val;
    exp_beat   = 1'b0;
    if (v) begin
      k    = hist.size();
      mn   = (W+8)'(window_mean(k));
      pass = (k >= AVG_LEN) && (((W+8)'(val) << 1) > mn * 3) &&
             (val >= W'(MIN_FLUX)) && (k - last_ev > REFRACT);
`ifdef PEAK_PICK_EN
      if (pend && k >= 1) exp_beat = (hist[k-1] >= val);
      if (exp_beat) begin
        last_ev = k;
        m_cnt   = m_cnt + 16'd1;
      end
      pend = 1'b0;
      if (pass && !exp_beat && k >= 1) pend = (val > hist[k-1]);
`else
      exp_beat = pass;
      if (pass) begin
        last_ev = k;
        m_cnt   = m_cnt + 16'd1;
      end
`endif
      hist.push_back(val);
    end
    @(negedge clk);
    chk("flux_out_valid", W'(flux_out_valid), W'(v));
    chk("beat_valid", W'(beat_valid), W'(exp_beat));
    if (v) chk("flux_out", flux_out, val);
    chk("mean_out", mean_out, window_mean(hist.size()));
    chk("onset_count", W'(onset_count), W'(m_cnt));
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    flux_valid = 1'b0;
    flux_in    = '0;
    @(negedge clk);
    chk("rst_valid", W'(flux_out_valid), '0);
    chk("rst_beat", W'(beat_valid), '0);
    chk("rst_flux", flux_out, '0);
    chk("rst_mean", mean_out, '0);
    chk("rst_count", W'(onset_count), '0);
    reset = 1'b0;
    model_clear();
  endtask

  function automatic logic [W-1:0] rand_flux();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel <= 5) return W'($urandom_range(50, 150));
    if (sel <= 7) return W'($urandom_range(150, 600));
    if (sel == 8) return W'($urandom_range(0, 63));
    return W'({$urandom(), $urandom(), $urandom()});
  endfunction

  initial begin
    reset      = 1'b1;
    flux_valid = 1'b0;
    flux_in    = '0;
    model_clear();
    @(negedge clk);

    // Warmup at 100, then 151 just clears 1.5x mean.
    do_reset();
    for (int i = 0; i < 16; i++) frame(1'b1, W'(100));
    chk("t1_mean_after_warmup", mean_out, W'(100));
    frame(1'b1, W'(151));
`ifndef PEAK_PICK_EN
    chk("t1_beat_151", W'(beat_valid), W'(1));
    chk("t1_count", W'(onset_count), W'(1));
`endif
    frame(1'b0, '0);

    // 150 sits exactly on the threshold and must not flag.
    do_reset();
    for (int i = 0; i < 16; i++) frame(1'b1, W'(100));
    frame(1'b1, W'(150));
    chk("t2_beat_150", W'(beat_valid), W'(0));

    // Refractory: a run of 400 after a mean of 100.
    do_reset();
    for (int i = 0; i < 16; i++) frame(1'b1, W'(100));
    for (int i = 0; i < 6; i++) frame(1'b1, W'(400));
    frame(1'b0, '0);

    // Floor boundary with a zero-mean warmup.
    do_reset();
    for (int i = 0; i < 16; i++) frame(1'b1, W'(0));
    frame(1'b1, W'(63));
    chk("t4_beat_63", W'(beat_valid), W'(0));
    frame(1'b1, W'(64));
`ifndef PEAK_PICK_EN
    chk("t4_beat_64", W'(beat_valid), W'(1));
`endif

    // Flat input never flags.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      frame(1'b1, W'(100));
      chk("flat_beat", W'(beat_valid), W'(0));
    end

    // Ramp burst interrupted by an asynchronous reset.
    do_reset();
    for (int i = 0; i < 25; i++) frame(1'b1, W'(i));
    #2;
    reset      = 1'b1;
    flux_valid = 1'b0;
    #1;
    chk("t5_async_valid", W'(flux_out_valid), '0);
    chk("t5_async_flux", flux_out, '0);
    chk("t5_async_count", W'(onset_count), '0);
    chk("t5_async_mean", mean_out, '0);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    for (int i = 0; i < 16; i++) begin
      frame(1'b1, W'(1000 + 200 * i));
      chk("t5_warmup_beat", W'(beat_valid), W'(0));
    end
    frame(1'b1, W'(9000));
    frame(1'b1, W'(100));
    frame(1'b0, '0);

`ifdef PEAK_PICK_EN
    // Peak pick: 300, 350, 200 -> flag lands on the 200 output frame.
    do_reset();
    for (int i = 0; i < 16; i++) frame(1'b1, W'(100));
    frame(1'b1, W'(300));
    chk("t6_beat_300", W'(beat_valid), W'(0));
    frame(1'b1, W'(350));
    chk("t6_beat_350", W'(beat_valid), W'(0));
    frame(1'b1, W'(200));
    chk("t6_beat_200", W'(beat_valid), W'(1));
    frame(1'b0, '0);
`endif

    // Randomized frames with gaps, spikes, sub-floor and full-width values.
    for (int r = 0; r < 6; r++) begin
      do_reset();
      for (int n = 0; n < 150; n++) begin
        if ($urandom_range(0, 9) < 8) frame(1'b1, rand_flux());
        else frame(1'b0, W'($urandom()));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
